sfp_io_pipe: RTL and testbench

- Parametrised successor to the single-stage differential I/O register between the SFP transceiver pins and the GMII/SGMII logic.
- Carries NUM_CH channels. Each channel has one RX and one TX differential pair, delayed through a configurable register pipeline.
- Adds per-channel RX polarity inversion, a global TX-to-RX loopback mode, a pipeline-fill indicator and per-channel saturating invalid-pair counters for link bring-up debug.

---
 rtl/sfp_io_pipe.sv | 114 +++++++++++
 tb/tb_sfp_io_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sfp_io_pipe.sv
// rtl/sfp_io_pipe.sv - multi-channel SFP differential I/O register pipeline with debug counters
// RX/TX pairs delayed STAGES edges; RX side adds polarity swap, loopback, fill flag and invalid-pair counters.

module sfp_io_pipe #(
    parameter int NUM_CH    = 2,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        loopback_en,
    input  logic [NUM_CH-1:0]           invert_rx,
    input  logic                        err_clr,
    input  logic [NUM_CH-1:0]           rxp_in,
    input  logic [NUM_CH-1:0]           rxn_in,
    input  logic [NUM_CH-1:0]           txp_in,
    input  logic [NUM_CH-1:0]           txn_in,
    output logic [NUM_CH-1:0]           rxp_out,
    output logic [NUM_CH-1:0]           rxn_out,
    output logic [NUM_CH-1:0]           txp_out,
    output logic [NUM_CH-1:0]           txn_out,
    output logic                        pipe_ready,
    output logic [NUM_CH*ERR_CNT_W-1:0] rx_err_cnt
);

    localparam int FILL_W = $clog2(STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(STAGES);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(STAGES - 1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    logic [NUM_CH-1:0] rxp_q [STAGES];
    logic [NUM_CH-1:0] rxn_q [STAGES];
    logic [NUM_CH-1:0] txp_q [STAGES];
    logic [NUM_CH-1:0] txn_q [STAGES];

    logic [NUM_CH-1:0] src_p;
    logic [NUM_CH-1:0] src_n;
    logic [NUM_CH-1:0] rx_d_p;
    logic [NUM_CH-1:0] rx_d_n;

    logic [FILL_W-1:0]    fill_cnt;
    logic                 ready_q;
    logic [ERR_CNT_W-1:0] err_cnt [NUM_CH];

    // Mode controls are applied before stage 1 so they travel with the data.
    assign src_p  = loopback_en ? txp_in : rxp_in;
    assign src_n  = loopback_en ? txn_in : rxn_in;
    assign rx_d_p = (src_p & ~invert_rx) | (src_n & invert_rx);
    assign rx_d_n = (src_n & ~invert_rx) | (src_p & invert_rx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                rxp_q[s] <= '0;
                rxn_q[s] <= '1;
                txp_q[s] <= '0;
                txn_q[s] <= '1;
            end
        end else begin
            for (int s = STAGES - 1; s > 0; s--) begin
                rxp_q[s] <= rxp_q[s-1];
                rxn_q[s] <= rxn_q[s-1];
                txp_q[s] <= txp_q[s-1];
                txn_q[s] <= txn_q[s-1];
            end
            rxp_q[0] <= rx_d_p;
            rxn_q[0] <= rx_d_n;
            txp_q[0] <= txp_in;
            txn_q[0] <= txn_in;
        end
    end

    assign rxp_out = rxp_q[STAGES-1];
    assign rxn_out = rxn_q[STAGES-1];
    assign txp_out = txp_q[STAGES-1];
    assign txn_out = txn_q[STAGES-1];

    // Ready is set on the edge that flushes the last reset value out of the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + FILL_ONE;
            end
            ready_q <= ready_q | (fill_cnt == FILL_LAST);
        end
    end

    assign pipe_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                err_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (err_clr) begin
                    err_cnt[c] <= '0;
                end else if (ready_q && (rxp_out[c] == rxn_out[c]) && (err_cnt[c] != '1)) begin
                    err_cnt[c] <= err_cnt[c] + ERR_ONE;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign rx_err_cnt[g*ERR_CNT_W +: ERR_CNT_W] = err_cnt[g];
    end

endmodule

// File: tb/tb_sfp_io_pipe.sv
// tb/tb_sfp_io_pipe.sv - self-checking bench for sfp_io_pipe
// Queue-based delay model checked every cycle, plus literal expectations along the directed sequence.

module tb_sfp_io_pipe;

    localparam int NUM_CH    = 2;
    localparam int STAGES    = 3;
    localparam int ERR_CNT_W = 4;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic loopback_en;
    logic err_clr;
    logic [NUM_CH-1:0] invert_rx, rxp_in, rxn_in, txp_in, txn_in;
    logic [NUM_CH-1:0] rxp_out, rxn_out, txp_out, txn_out;
    logic pipe_ready;
    logic [NUM_CH*ERR_CNT_W-1:0] rx_err_cnt;

    always #5 clk = ~clk;

    sfp_io_pipe #(.NUM_CH(NUM_CH), .STAGES(STAGES), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en), .invert_rx(invert_rx),
        .err_clr(err_clr), .rxp_in(rxp_in), .rxn_in(rxn_in), .txp_in(txp_in), .txn_in(txn_in),
        .rxp_out(rxp_out), .rxn_out(rxn_out), .txp_out(txp_out), .txn_out(txn_out),
        .pipe_ready(pipe_ready), .rx_err_cnt(rx_err_cnt)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] rp;
        logic [NUM_CH-1:0] rn;
        logic [NUM_CH-1:0] tp;
        logic [NUM_CH-1:0] tn;
    } slot_t;

    slot_t q[$];
    int    edges;
    int    cnt [NUM_CH];
    int    vectors = 0;
    int    miscompares = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t capture();
        slot_t s;
        for (int c = 0; c < NUM_CH; c++) begin
            logic p, n;
            p = loopback_en ? txp_in[c] : rxp_in[c];
            n = loopback_en ? txn_in[c] : rxn_in[c];
            s.rp[c] = invert_rx[c] ? n : p;
            s.rn[c] = invert_rx[c] ? p : n;
        end
        s.tp = txp_in;
        s.tn = txn_in;
        return s;
    endfunction

    // Output is the oldest of STAGES captured values; counters follow the visible output.
    always @(posedge clk or negedge rst_n) begin : model
        slot_t cur, rst_slot;
        if (!rst_n) begin
            rst_slot = '{rp: '0, rn: '1, tp: '0, tn: '1};
            q.delete();
            for (int s = 0; s < STAGES; s++) q.push_back(rst_slot);
            edges = 0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        end else begin
            cur = q[0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (err_clr) cnt[c] = 0;
                else if (edges >= STAGES && cur.rp[c] == cur.rn[c] && cnt[c] < CNT_MAX) cnt[c]++;
            end
            q.push_back(capture());
            void'(q.pop_front());
            if (edges < STAGES) edges++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model rxp_out", 32'(rxp_out), 32'(q[0].rp));
            check("model rxn_out", 32'(rxn_out), 32'(q[0].rn));
            check("model txp_out", 32'(txp_out), 32'(q[0].tp));
            check("model txn_out", 32'(txn_out), 32'(q[0].tn));
            check("model pipe_ready", 32'(pipe_ready), 32'(edges >= STAGES));
            for (int c = 0; c < NUM_CH; c++)
                check("model rx_err_cnt", 32'(rx_err_cnt[c*ERR_CNT_W +: ERR_CNT_W]), 32'(cnt[c]));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] cnt_of(input int c);
        return 32'(rx_err_cnt[c*ERR_CNT_W +: ERR_CNT_W]);
    endfunction

    initial begin
        rst_n = 1'b0; loopback_en = 1'b0; err_clr = 1'b0; invert_rx = 2'b00;
        rxp_in = 2'b00; rxn_in = 2'b11; txp_in = 2'b00; txn_in = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_en = 1'b1;
        check("reset rxp_out", 32'(rxp_out), 32'h0);
        check("reset rxn_out", 32'(rxn_out), 32'h3);
        check("reset pipe_ready", 32'(pipe_ready), 32'h0);
        check("reset cnt", 32'(rx_err_cnt), 32'h0);

        // Latency and fill
        rst_n = 1'b1;
        rxp_in = 2'b01; rxn_in = 2'b10; txp_in = 2'b10; txn_in = 2'b01;
        tick(2);
        check("lat rxp_out edge2", 32'(rxp_out), 32'h0);
        check("lat txp_out edge2", 32'(txp_out), 32'h0);
        check("lat ready edge2", 32'(pipe_ready), 32'h0);
        tick();
        check("lat rxp_out edge3", 32'(rxp_out), 32'h1);
        check("lat rxn_out edge3", 32'(rxn_out), 32'h2);
        check("lat txp_out edge3", 32'(txp_out), 32'h2);
        check("lat ready edge3", 32'(pipe_ready), 32'h1);

        // Inversion
        invert_rx = 2'b10; rxp_in = 2'b11; rxn_in = 2'b00;
        tick(3);
        check("inv rxp_out", 32'(rxp_out), 32'h1);
        check("inv rxn_out", 32'(rxn_out), 32'h2);
        invert_rx = 2'b00;
        tick(2);
        check("inv toggle edge2", 32'(rxp_out), 32'h1);
        tick();
        check("inv toggle edge3", 32'(rxp_out), 32'h3);

        // Loopback
        loopback_en = 1'b1; txp_in = 2'b10; txn_in = 2'b01; rxp_in = 2'b01; rxn_in = 2'b10;
        tick(3);
        check("lb rxp_out", 32'(rxp_out), 32'h2);
        check("lb txp_out", 32'(txp_out), 32'h2);
        loopback_en = 1'b0;
        tick(2);
        check("lb off edge2", 32'(rxp_out), 32'h2);
        tick();
        check("lb off edge3", 32'(rxp_out), 32'h1);

        // Saturating counter: ch0 p=n=1, ch1 valid
        rxp_in = 2'b01; rxn_in = 2'b11;
        tick(4);
        check("cnt first", cnt_of(0), 32'd1);
        tick(19);
        check("cnt sat ch0", cnt_of(0), 32'd15);
        check("cnt ch1", cnt_of(1), 32'd0);
        tick(2);
        check("cnt hold ch0", cnt_of(0), 32'd15);

        // Clear priority
        err_clr = 1'b1;
        tick();
        check("clr zero", cnt_of(0), 32'd0);
        err_clr = 1'b0;
        tick();
        check("clr resume", cnt_of(0), 32'd1);
        tick(2);
        check("clr resume 3", cnt_of(0), 32'd3);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("arst rxp_out", 32'(rxp_out), 32'h0);
        check("arst rxn_out", 32'(rxn_out), 32'h3);
        check("arst txp_out", 32'(txp_out), 32'h0);
        check("arst txn_out", 32'(txn_out), 32'h3);
        check("arst ready", 32'(pipe_ready), 32'h0);
        check("arst cnt", 32'(rx_err_cnt), 32'h0);
        tick();
        rst_n = 1'b1; rxp_in = 2'b01; rxn_in = 2'b10;
        tick(2);
        check("rerelease ready edge2", 32'(pipe_ready), 32'h0);
        tick();
        check("rerelease ready edge3", 32'(pipe_ready), 32'h1);
        tick(2);
        check("rerelease cnt", 32'(rx_err_cnt), 32'h0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
